// File: rtl/adc_avg_storage_if.sv
// Modular ADC response stream: one beat per cycle, no backpressure.
interface adc_avg_storage_if #(
    parameter int CH_W   = 5,
    parameter int DATA_W = 12
);
    logic              AdcResponseValid;
    logic [CH_W-1:0]   AdcResponseChannel;
    logic [DATA_W-1:0] AdcResponseData;

    modport master (output AdcResponseValid, output AdcResponseChannel, output AdcResponseData);
    modport slave  (input  AdcResponseValid, input  AdcResponseChannel, input  AdcResponseData);
endinterface

// File: rtl/adc_avg_storage.sv
// Per-channel ADC block averager plus raw temperature capture and end-of-sequence strobe.
// Define ADC_AVG_STORAGE_ROUND_EN to publish round-half-up averages instead of truncated ones.
module adc_avg_lane #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              Clock_qsys,
    input  logic              Reset,
    input  logic              clear,
    input  logic              hit,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] value,
    output logic              ch_valid
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  acc, sum;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] avg;

    // ACC_W is wide enough that 2^AVG_LOG2 full-scale samples never wrap
    assign sum = acc + ACC_W'(data);

`ifdef ADC_AVG_STORAGE_ROUND_EN
    if (AVG_LOG2 > 0) begin : g_rnd
        // adding half an LSB before the shift is the same as adding the bit just below it
        logic [DATA_W:0] rq;
        assign rq  = {1'b0, sum[AVG_LOG2 +: DATA_W]} + (DATA_W+1)'(sum[AVG_LOG2-1]);
        assign avg = rq[DATA_W] ? {DATA_W{1'b1}} : rq[DATA_W-1:0];
    end else begin : g_trn
        assign avg = sum[DATA_W-1:0];
    end
`else
    assign avg = sum[AVG_LOG2 +: DATA_W];
`endif

    always_ff @(posedge Clock_qsys) begin
        if (Reset) begin
            acc      <= '0;
            cnt      <= '0;
            value    <= '0;
            ch_valid <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (hit) begin
            if (cnt == CNT_LAST) begin
                value    <= avg;
                ch_valid <= 1'b1;
                acc      <= '0;
                cnt      <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module adc_avg_storage #(
    parameter int NUM_CH   = 9,
    parameter int DATA_W   = 12,
    parameter int CH_W     = 5,
    parameter int AVG_LOG2 = 2,
    parameter int TRIG_CH  = 17
) (
    input  logic                     Clock_qsys,
    input  logic                     Reset,
    input  logic                     AvgClear,
    adc_avg_storage_if.slave         adc_rsp,
    output logic [NUM_CH*DATA_W-1:0] AdcValues,
    output logic [NUM_CH-1:0]        AdcChValid,
    output logic [DATA_W-1:0]        AdcTempValue,
    output logic                     AdcRefresh
);
    localparam logic [CH_W-1:0] TRIG_ID = CH_W'(TRIG_CH);

    logic [NUM_CH-1:0][DATA_W-1:0] ch_value;
    logic [NUM_CH-1:0]             ch_vld;
    logic                          trig_hit;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        adc_avg_lane #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_lane (
            .Clock_qsys (Clock_qsys),
            .Reset      (Reset),
            .clear      (AvgClear),
            .hit        (adc_rsp.AdcResponseValid && (adc_rsp.AdcResponseChannel == CH_W'(k))),
            .data       (adc_rsp.AdcResponseData),
            .value      (ch_value[k]),
            .ch_valid   (ch_vld[k])
        );
    end

    assign AdcValues  = ch_value;
    assign AdcChValid = ch_vld;
    assign trig_hit   = adc_rsp.AdcResponseValid && (adc_rsp.AdcResponseChannel == TRIG_ID);

    // temperature path ignores AvgClear so a sequence end is never lost
    always_ff @(posedge Clock_qsys) begin
        if (Reset) begin
            AdcTempValue <= '0;
            AdcRefresh   <= 1'b0;
        end else begin
            AdcRefresh <= trig_hit;
            if (trig_hit) AdcTempValue <= adc_rsp.AdcResponseData;
        end
    end
endmodule

// File: tb/tb_adc_avg_storage.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_adc_avg_storage;
    localparam int NCH = 9;
    localparam int DW  = 12;
    localparam int CW  = 5;
`ifdef ADC_AVG_STORAGE_ROUND_EN
    localparam int R0 = 102;
`else
    localparam int R0 = 101;
`endif
    localparam int K_FULL = 0, K_AVG = 1, K_TEMP = 2, K_B = 3;

    typedef struct {
        int                       cyc;
        int                       kind;
        int                       ch;
        logic [NCH-1:0][DW-1:0]   vals;
        logic [NCH-1:0]           vld;
        logic [DW-1:0]            temp;
        int                       val;
        logic                     vb;
    } exp_t;

    logic Clock_qsys = 1'b0;
    logic Reset      = 1'b1;
    logic AvgClear   = 1'b0;
    logic AvgClearB  = 1'b0;
    logic [NCH*DW-1:0] vals_a, vals_b;
    logic [NCH-1:0]    vld_a, vld_b;
    logic [DW-1:0]     temp_a, temp_b;
    logic              ref_a, ref_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [NCH-1:0][DW-1:0] m_vals;
    logic [NCH-1:0]         m_vld;
    logic [DW-1:0]          m_temp;

    adc_avg_storage_if #(.CH_W(CW), .DATA_W(DW)) aif ();
    adc_avg_storage_if #(.CH_W(CW), .DATA_W(DW)) bif ();

    adc_avg_storage #(.NUM_CH(NCH), .DATA_W(DW), .CH_W(CW), .AVG_LOG2(2), .TRIG_CH(17)) u_dut_a (
        .Clock_qsys(Clock_qsys), .Reset(Reset), .AvgClear(AvgClear), .adc_rsp(aif.slave),
        .AdcValues(vals_a), .AdcChValid(vld_a), .AdcTempValue(temp_a), .AdcRefresh(ref_a));

    adc_avg_storage #(.NUM_CH(NCH), .DATA_W(DW), .CH_W(CW), .AVG_LOG2(0), .TRIG_CH(17)) u_dut_b (
        .Clock_qsys(Clock_qsys), .Reset(Reset), .AvgClear(AvgClearB), .adc_rsp(bif.slave),
        .AdcValues(vals_b), .AdcChValid(vld_b), .AdcTempValue(temp_b), .AdcRefresh(ref_b));

    always #10 Clock_qsys = ~Clock_qsys;
    always @(posedge Clock_qsys) cyc <= cyc + 1;

    function automatic void push(input int kind, input int ch, input int dly, input int val, input logic vb);
        exp_t e;
        e.cyc = cyc + dly; e.kind = kind; e.ch = ch;
        e.vals = m_vals; e.vld = m_vld; e.temp = m_temp; e.val = val; e.vb = vb;
        q.push_back(e);
    endfunction

    task automatic check(input exp_t e);
        checks++;
        case (e.kind)
            K_FULL: if (vals_a !== e.vals || vld_a !== e.vld || temp_a !== e.temp || ref_a !== 1'b0) begin
                errors++;
                $display("FAIL full cyc=%0d got vals=%h vld=%b temp=%h ref=%b want vals=%h vld=%b temp=%h ref=0",
                         e.cyc, vals_a, vld_a, temp_a, ref_a, e.vals, e.vld, e.temp);
            end
            K_AVG: if (vals_a[e.ch*DW +: DW] !== e.vals[e.ch] || vld_a !== e.vld) begin
                errors++;
                $display("FAIL avg_ch%0d cyc=%0d got val=%0d vld=%b want val=%0d vld=%b",
                         e.ch, e.cyc, vals_a[e.ch*DW +: DW], vld_a, e.vals[e.ch], e.vld);
            end
            K_TEMP: if (temp_a !== e.temp || ref_a !== 1'b1) begin
                errors++;
                $display("FAIL temp cyc=%0d got temp=%h ref=%b want temp=%h ref=1", e.cyc, temp_a, ref_a, e.temp);
            end
            default: if (vals_b[e.ch*DW +: DW] !== DW'(e.val) || vld_b[e.ch] !== e.vb) begin
                errors++;
                $display("FAIL b_ch%0d cyc=%0d got val=%0d vld=%b want val=%0d vld=%b",
                         e.ch, e.cyc, vals_b[e.ch*DW +: DW], vld_b[e.ch], e.val, e.vb);
            end
        endcase
    endtask

    always @(negedge Clock_qsys) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                check(q[i]);
                q.delete(i);
            end
        end
    end

    task automatic drv_a(input logic clr, input logic v, input int ch, input int d);
        @(posedge Clock_qsys); #1;
        AvgClear = clr;
        aif.AdcResponseValid = v; aif.AdcResponseChannel = CW'(ch); aif.AdcResponseData = DW'(d);
        bif.AdcResponseValid = 1'b0;
    endtask

    task automatic drv_b(input logic v, input int ch, input int d);
        @(posedge Clock_qsys); #1;
        AvgClear = 1'b0; aif.AdcResponseValid = 1'b0;
        bif.AdcResponseValid = v; bif.AdcResponseChannel = CW'(ch); bif.AdcResponseData = DW'(d);
    endtask

    initial begin
        aif.AdcResponseValid = 1'b0; aif.AdcResponseChannel = '0; aif.AdcResponseData = '0;
        bif.AdcResponseValid = 1'b0; bif.AdcResponseChannel = '0; bif.AdcResponseData = '0;
        m_vals = '0; m_vld = '0; m_temp = '0;
        repeat (3) @(posedge Clock_qsys);
        #1 Reset = 1'b0;
        push(K_FULL, 0, 0, 0, 1'b0);
        push(K_B, 5, 0, 0, 1'b0);

        // ch0: 100..103 -> 406/4
        drv_a(0, 1, 0, 100); drv_a(0, 1, 0, 101); drv_a(0, 1, 0, 102);
        push(K_AVG, 0, 1, 0, 1'b0);
        drv_a(0, 1, 0, 103);
        m_vals[0] = DW'(R0); m_vld[0] = 1'b1; push(K_AVG, 0, 1, 0, 1'b0);

        // ch3 full scale, no wrap
        for (int i = 0; i < 4; i++) drv_a(0, 1, 3, 4095);
        m_vals[3] = 12'hFFF; m_vld[3] = 1'b1; push(K_AVG, 3, 1, 0, 1'b0);

        // ch1 partial, clear with a colliding beat, then fresh block
        drv_a(0, 1, 1, 10); drv_a(0, 1, 1, 20); drv_a(1, 1, 1, 999);
        for (int i = 0; i < 3; i++) drv_a(0, 1, 1, 40);
        push(K_AVG, 1, 1, 0, 1'b0);
        drv_a(0, 1, 1, 40);
        m_vals[1] = 12'd40; m_vld[1] = 1'b1; push(K_AVG, 1, 1, 0, 1'b0);
        push(K_AVG, 0, 1, 0, 1'b0);

        // ignored channel, then temperature beats
        drv_a(0, 1, 12, 777); push(K_FULL, 0, 1, 0, 1'b0);
        drv_a(0, 1, 17, 'h5A3); m_temp = 12'h5A3; push(K_TEMP, 0, 1, 0, 1'b0);
        drv_a(0, 0, 0, 0); push(K_FULL, 0, 1, 0, 1'b0);
        drv_a(0, 1, 17, 'h111); m_temp = 12'h111; push(K_TEMP, 0, 1, 0, 1'b0);
        drv_a(0, 1, 17, 'h222); m_temp = 12'h222; push(K_TEMP, 0, 1, 0, 1'b0);
        drv_a(0, 0, 0, 0); push(K_FULL, 0, 1, 0, 1'b0);
        drv_a(1, 1, 17, 'h0AB); m_temp = 12'h0AB; push(K_TEMP, 0, 1, 0, 1'b0);
        drv_a(0, 0, 0, 0); push(K_FULL, 0, 1, 0, 1'b0);

        // reset drops a partial ch2 block and all published state
        drv_a(0, 1, 2, 5); drv_a(0, 1, 2, 5); drv_a(0, 1, 2, 5);
        @(posedge Clock_qsys); #1 Reset = 1'b1; aif.AdcResponseValid = 1'b0;
        @(posedge Clock_qsys); #1 Reset = 1'b0;
        m_vals = '0; m_vld = '0; m_temp = '0; push(K_FULL, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) drv_a(0, 1, 2, 8);
        push(K_AVG, 2, 1, 0, 1'b0);
        drv_a(0, 1, 2, 8);
        m_vals[2] = 12'd8; m_vld[2] = 1'b1; push(K_AVG, 2, 1, 0, 1'b0);

        // single-sample build: direct copy, one cycle latency
        drv_b(1, 5, 1); push(K_B, 5, 1, 1, 1'b1);
        drv_b(1, 5, 2); push(K_B, 5, 1, 2, 1'b1);
        drv_b(1, 5, 3); push(K_B, 5, 1, 3, 1'b1);
        drv_b(0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clock_qsys);
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain got pending=%0d want pending=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
